// File: rtl/simd_dispatcher_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | simd_dispatcher_pkg: shared types for the SIMD command dispatcher  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package simd_dispatcher_pkg;

  localparam int DEF_PROC_COUNT = 4;
  localparam int DEF_DATA_W     = 32;
  localparam int DEF_ID_W       = 4;

  typedef enum logic [1:0] {
    BEAT_LD1   = 2'd0,
    BEAT_LD2   = 2'd1,
    BEAT_INFO  = 2'd2,
    BEAT_WRITE = 2'd3
  } beat_t;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_t;

  typedef struct packed {
    logic [DEF_DATA_W-1:0] ld1;
    logic [DEF_DATA_W-1:0] ld2;
    logic [DEF_DATA_W-1:0] info;
    logic [DEF_DATA_W-1:0] wr;
    logic [DEF_ID_W-1:0]   id;
  } dispatch_cmd_t;

endpackage
`default_nettype wire

// File: rtl/simd_dispatcher_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | simd_dispatcher_if: issuer request, core beat and retire signals   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
interface simd_dispatcher_if
  import simd_dispatcher_pkg::*;
#(
  parameter int PROC_COUNT = DEF_PROC_COUNT,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int ID_W       = DEF_ID_W
) ();
  localparam int PIDX_W = $clog2(PROC_COUNT);

  logic                  req_valid;
  logic                  req_ready;
  logic [DATA_W-1:0]     req_ld1;
  logic [DATA_W-1:0]     req_ld2;
  logic [DATA_W-1:0]     req_info;
  logic [DATA_W-1:0]     req_wr;
  logic [ID_W-1:0]       req_id;
  logic [PROC_COUNT-1:0] en_arr;
  logic                  beat_valid;
  beat_t                 beat_type;
  logic [DATA_W-1:0]     beat_data;
  logic                  ack;
  logic [PROC_COUNT-1:0] finish;
  logic [PROC_COUNT-1:0] busy;
  logic                  retire_valid;
  logic [ID_W-1:0]       retire_id;
  logic [PIDX_W-1:0]     retire_proc;

  modport master (
    output req_valid, req_ld1, req_ld2, req_info, req_wr, req_id, ack, finish,
    input  req_ready, en_arr, beat_valid, beat_type, beat_data, busy,
           retire_valid, retire_id, retire_proc
  );

  modport slave (
    input  req_valid, req_ld1, req_ld2, req_info, req_wr, req_id, ack, finish,
    output req_ready, en_arr, beat_valid, beat_type, beat_data, busy,
           retire_valid, retire_id, retire_proc
  );

endinterface
`default_nettype wire

// File: rtl/simd_dispatcher_rr_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | rr_arbiter: first requester searching from i_ptr+1, wrapping       |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic [N-1:0]     o_grant,
  output logic [IDX_W-1:0] o_grant_idx,
  output logic             o_grant_valid
);

  int w_dist;
  int w_best;

  // Distance 0 is the slot right after the pointer; the pointer itself is last.
  always_comb begin
    o_grant       = '0;
    o_grant_idx   = '0;
    o_grant_valid = 1'b0;
    w_dist        = 0;
    w_best        = N;
    for (int i = 0; i < N; i++) begin
      if (i_req[i]) begin
        w_dist = (i + 2 * N - 1 - int'(i_ptr)) % N;
        if (w_dist < w_best) begin
          w_best        = w_dist;
          o_grant_idx   = IDX_W'(i);
          o_grant_valid = 1'b1;
        end
      end
    end
    if (o_grant_valid) o_grant[o_grant_idx] = 1'b1;
  end

endmodule
`default_nettype wire

// File: rtl/simd_dispatcher.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | simd_dispatcher: sends a command to a free SIMD core as four beats |
// | and serializes core finish pulses into retire events. Rev 1.0      |
// +--------------------------------------------------------------------+
module simd_dispatcher
  import simd_dispatcher_pkg::*;
#(
  parameter int PROC_COUNT = DEF_PROC_COUNT,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int ID_W       = DEF_ID_W
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  simd_dispatcher_if.slave  bus
);

  localparam int PIDX_W = $clog2(PROC_COUNT);

  state_t                         r_state;
  state_t                         w_state_next;
  beat_t                          r_beat_cnt;
  logic [PIDX_W-1:0]              r_grant_idx;
  logic [PIDX_W-1:0]              r_rr_ptr;
  logic [3:0][DATA_W-1:0]         r_payload;
  logic [PROC_COUNT-1:0][ID_W-1:0] r_id;
  logic [PROC_COUNT-1:0]          r_busy;
  logic [PROC_COUNT-1:0]          r_pending;
  logic                           r_retire_valid;
  logic [ID_W-1:0]                r_retire_id;
  logic [PIDX_W-1:0]              r_retire_proc;

  logic                           w_send;
  logic                           w_ready;
  logic                           w_accept;
  logic                           w_beat_done;
  logic [PROC_COUNT-1:0]          w_arb_grant;
  logic [PIDX_W-1:0]              w_arb_idx;
  logic                           w_arb_valid;
  logic [PROC_COUNT-1:0]          w_pend_eff;
  logic [PROC_COUNT-1:0]          w_ret_cand;
  logic [PROC_COUNT-1:0]          w_ret_mask;
  logic [PIDX_W-1:0]              w_ret_idx;
  logic                           w_ret_valid;

  assign w_send      = (r_state == ST_SEND);
  assign w_ready     = (r_state == ST_IDLE) && !(&r_busy);
  assign w_accept    = bus.req_valid && w_ready && w_arb_valid;
  assign w_beat_done = w_send && bus.ack && (r_beat_cnt == BEAT_WRITE);

  rr_arbiter #(
    .N     (PROC_COUNT),
    .IDX_W (PIDX_W)
  ) u_rr_arbiter (
    .i_req         (~r_busy),
    .i_ptr         (r_rr_ptr),
    .o_grant       (w_arb_grant),
    .o_grant_idx   (w_arb_idx),
    .o_grant_valid (w_arb_valid)
  );

  // A finish arriving this cycle is retirable immediately; the core being fed stays put.
  assign w_pend_eff = r_pending | (bus.finish & r_busy);

  always_comb begin
    w_ret_cand  = w_pend_eff;
    w_ret_valid = 1'b0;
    w_ret_idx   = '0;
    w_ret_mask  = '0;
    if (w_send) w_ret_cand[r_grant_idx] = 1'b0;
    for (int i = PROC_COUNT - 1; i >= 0; i--) begin
      if (w_ret_cand[i]) begin
        w_ret_valid = 1'b1;
        w_ret_idx   = PIDX_W'(i);
      end
    end
    if (w_ret_valid) w_ret_mask[w_ret_idx] = 1'b1;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (w_accept)    w_state_next = ST_SEND;
      ST_SEND: if (w_beat_done) w_state_next = ST_IDLE;
      default:                  w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) r_state <= ST_IDLE;
    else         r_state <= w_state_next;
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_beat_cnt     <= BEAT_LD1;
      r_grant_idx    <= '0;
      r_rr_ptr       <= '0;
      r_payload      <= '0;
      r_id           <= '0;
      r_busy         <= '0;
      r_pending      <= '0;
      r_retire_valid <= 1'b0;
      r_retire_id    <= '0;
      r_retire_proc  <= '0;
    end else begin
      r_busy         <= (r_busy & ~w_ret_mask) | (w_accept ? w_arb_grant : '0);
      r_pending      <= w_pend_eff & ~w_ret_mask;
      r_retire_valid <= w_ret_valid;
      r_retire_id    <= w_ret_valid ? r_id[w_ret_idx] : '0;
      r_retire_proc  <= w_ret_valid ? w_ret_idx : '0;
      if (w_accept) begin
        r_payload            <= {bus.req_wr, bus.req_info, bus.req_ld2, bus.req_ld1};
        r_id[w_arb_idx]      <= bus.req_id;
        r_grant_idx          <= w_arb_idx;
        r_rr_ptr             <= w_arb_idx;
        r_beat_cnt           <= BEAT_LD1;
      end else if (w_send && bus.ack) begin
        r_beat_cnt <= beat_t'(r_beat_cnt + 2'd1);
      end
    end
  end

  assign bus.req_ready    = w_ready;
  assign bus.beat_valid   = w_send;
  assign bus.en_arr       = w_send ? (PROC_COUNT'(1) << r_grant_idx) : '0;
  assign bus.beat_type    = w_send ? r_beat_cnt : BEAT_LD1;
  assign bus.beat_data    = w_send ? r_payload[r_beat_cnt] : '0;
  assign bus.busy         = r_busy;
  assign bus.retire_valid = r_retire_valid;
  assign bus.retire_id    = r_retire_id;
  assign bus.retire_proc  = r_retire_proc;

endmodule
`default_nettype wire

// File: tb/tb_simd_dispatcher.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_simd_dispatcher: directed vectors for simd_dispatcher           |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_simd_dispatcher;
  import simd_dispatcher_pkg::*;

  logic i_clk;
  logic i_rstn;
  int   n_checks;
  int   n_errors;

  simd_dispatcher_if bus ();

  simd_dispatcher u_dut (
    .i_clk  (i_clk),
    .i_rstn (i_rstn),
    .bus    (bus)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  function automatic dispatch_cmd_t mk_cmd(input logic [3:0] id);
    dispatch_cmd_t c;
    c.ld1  = 32'h1000_0000 | 32'(id);
    c.ld2  = 32'h2000_0000 | 32'(id);
    c.info = 32'h3000_0000 | 32'(id);
    c.wr   = 32'h4000_0000 | 32'(id);
    c.id   = id;
    return c;
  endfunction

  task automatic set_req(input dispatch_cmd_t c);
    bus.req_ld1  = c.ld1;
    bus.req_ld2  = c.ld2;
    bus.req_info = c.info;
    bus.req_wr   = c.wr;
    bus.req_id   = c.id;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    dispatch_cmd_t c;
    logic [3:0] exp_grant [4];
    exp_grant = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
    n_checks = 0;
    n_errors = 0;
    i_rstn        = 1'b0;
    bus.req_valid = 1'b0;
    bus.ack       = 1'b0;
    bus.finish    = '0;
    set_req(mk_cmd(4'd0));

    // Reset state
    #2;
    chk("rst_beat_valid", bus.beat_valid, 1'b0);
    chk("rst_en_arr", bus.en_arr, 4'b0000);
    chk("rst_busy", bus.busy, 4'b0000);
    chk("rst_retire_valid", bus.retire_valid, 1'b0);
    chk("rst_beat_data", bus.beat_data, 32'h0);
    tick();
    tick();
    i_rstn = 1'b1;
    tick();
    chk("rst_ready", bus.req_ready, 1'b1);

    // Single request id=5, ack held high -> core 1
    c = mk_cmd(4'd5);
    set_req(c);
    bus.req_valid = 1'b1;
    bus.ack       = 1'b1;
    tick();
    bus.req_valid = 1'b0;
    chk("a_en_arr", bus.en_arr, 4'b0010);
    chk("a_busy", bus.busy, 4'b0010);
    chk("a_ready_busy", bus.req_ready, 1'b0);
    chk("a_type0", bus.beat_type, 2'd0);
    chk("a_data0", bus.beat_data, c.ld1);
    tick();
    chk("a_type1", bus.beat_type, 2'd1);
    chk("a_data1", bus.beat_data, c.ld2);
    tick();
    chk("a_type2", bus.beat_type, 2'd2);
    chk("a_data2", bus.beat_data, c.info);
    tick();
    chk("a_type3", bus.beat_type, 2'd3);
    chk("a_data3", bus.beat_data, c.wr);
    tick();
    chk("a_idle_valid", bus.beat_valid, 1'b0);
    chk("a_ready_t5", bus.req_ready, 1'b1);

    // Ack withheld for three cycles on INFO -> core 2
    c = mk_cmd(4'd6);
    set_req(c);
    bus.req_valid = 1'b1;
    tick();
    bus.req_valid = 1'b0;
    chk("b_en_arr", bus.en_arr, 4'b0100);
    tick();
    chk("b_type1", bus.beat_type, 2'd1);
    tick();
    bus.ack = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("b_hold_type%0d", k), bus.beat_type, 2'd2);
      chk($sformatf("b_hold_data%0d", k), bus.beat_data, c.info);
      tick();
    end
    chk("b_hold_type3", bus.beat_type, 2'd2);
    bus.ack = 1'b1;
    tick();
    chk("b_write_type", bus.beat_type, 2'd3);
    chk("b_write_data", bus.beat_data, c.wr);
    tick();
    chk("b_idle", bus.beat_valid, 1'b0);
    chk("b_busy", bus.busy, 4'b0110);

    // Finish on an idle core is ignored
    bus.finish = 4'b1000;
    tick();
    bus.finish = '0;
    chk("c_no_retire", bus.retire_valid, 1'b0);
    chk("c_busy", bus.busy, 4'b0110);
    tick();
    chk("c_no_retire2", bus.retire_valid, 1'b0);

    // Reset during LD2 beat of a request to core 3
    set_req(mk_cmd(4'd7));
    bus.req_valid = 1'b1;
    tick();
    bus.req_valid = 1'b0;
    chk("d_en_arr", bus.en_arr, 4'b1000);
    tick();
    chk("d_type_ld2", bus.beat_type, 2'd1);
    i_rstn = 1'b0;
    #1;
    chk("d_rst_valid", bus.beat_valid, 1'b0);
    chk("d_rst_en_arr", bus.en_arr, 4'b0000);
    chk("d_rst_busy", bus.busy, 4'b0000);
    chk("d_rst_data", bus.beat_data, 32'h0);
    #2;
    i_rstn = 1'b1;
    tick();
    chk("d_ready", bus.req_ready, 1'b1);
    chk("d_busy_after", bus.busy, 4'b0000);

    // Four back-to-back requests -> cores 1,2,3,0
    for (int n = 0; n < 4; n++) begin
      set_req(mk_cmd(4'(8 + n)));
      bus.req_valid = 1'b1;
      chk($sformatf("e_ready%0d", n), bus.req_ready, 1'b1);
      tick();
      bus.req_valid = 1'b0;
      chk($sformatf("e_grant%0d", n), bus.en_arr, exp_grant[n]);
      repeat (4) tick();
    end
    chk("e_busy_full", bus.busy, 4'b1111);
    chk("e_ready_full", bus.req_ready, 1'b0);

    // Fifth request is held while all cores are busy
    c = mk_cmd(4'd12);
    set_req(c);
    bus.req_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("e_held%0d", k), bus.beat_valid, 1'b0);
    end

    // Simultaneous finish on cores 1 and 3 drains in index order
    bus.finish = 4'b1010;
    tick();
    bus.finish = '0;
    chk("f_ret1_valid", bus.retire_valid, 1'b1);
    chk("f_ret1_proc", bus.retire_proc, 2'd1);
    chk("f_ret1_id", bus.retire_id, 4'd8);
    chk("f_ret1_busy", bus.busy, 4'b1101);
    chk("f_ret1_ready", bus.req_ready, 1'b1);
    tick();
    bus.req_valid = 1'b0;
    chk("f_ret2_valid", bus.retire_valid, 1'b1);
    chk("f_ret2_proc", bus.retire_proc, 2'd3);
    chk("f_ret2_id", bus.retire_id, 4'd10);
    chk("f_ret2_busy", bus.busy, 4'b0111);
    chk("f_regrant_en", bus.en_arr, 4'b0010);
    chk("f_regrant_data", bus.beat_data, c.ld1);
    tick();
    chk("f_ret_done", bus.retire_valid, 1'b0);
    repeat (3) tick();
    chk("f_idle", bus.beat_valid, 1'b0);
    chk("f_busy_end", bus.busy, 4'b0111);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
